pipe_exe_md: RTL

Execute stage of the five-stage pipeline, sitting between the ID/EX register and the EX/MEM register. It computes the single-cycle ALU/shift/link result for the instruction in EX. It also owns the HI/LO registers and an iterative 32-cycle multiply/divide unit that runs in the background, and raises `estall` to freeze the front of the pipeline when an instruction needs a result the unit has not finished.

---
 rtl/pipe_exe_md_if.sv | 36 +++
 rtl/pipe_exe_md.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/pipe_exe_md_if.sv
// ID/EX-to-EX/MEM bundle for the execute stage: operands and controls in, result and gated controls out.
interface pipe_exe_md_if;
  logic [31:0] ea;
  logic [31:0] eb;
  logic [31:0] eimm;
  logic [31:0] epc4;
  logic [3:0]  ealuc;
  logic        ealuimm;
  logic        eshift;
  logic        ejal;
  logic [2:0]  emdop;
  logic        ewreg;
  logic        em2reg;
  logic        ewmem;
  logic [4:0]  ern0;

  logic [31:0] ealu;
  logic [4:0]  ern;
  logic        xwreg;
  logic        xm2reg;
  logic        xwmem;
  logic        estall;
  logic        mdbusy;

  modport master (
    output ea, eb, eimm, epc4, ealuc, ealuimm, eshift, ejal, emdop,
           ewreg, em2reg, ewmem, ern0,
    input  ealu, ern, xwreg, xm2reg, xwmem, estall, mdbusy
  );

  modport slave (
    input  ea, eb, eimm, epc4, ealuc, ealuimm, eshift, ejal, emdop,
           ewreg, em2reg, ewmem, ern0,
    output ealu, ern, xwreg, xm2reg, xwmem, estall, mdbusy
  );
endinterface

// File: rtl/pipe_exe_md.sv
// Execute stage: combinational ALU/shift/link result plus HI/LO and a background
// radix-2 multiply/divide unit that stalls the front end only when its result is needed.
module pipe_exe_md #(
  parameter int MD_CYCLES = 32
) (
  input  logic          clock,
  input  logic          resetn,
  pipe_exe_md_if.slave  bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [5:0] LAST_STEP = 6'(MD_CYCLES - 1);

  state_t      state;
  logic [5:0]  cnt;
  logic        md_mul;
  logic        neg_q;
  logic        neg_r;
  logic [31:0] opb;
  logic [31:0] acc_hi;
  logic [31:0] acc_lo;
  logic [31:0] hi;
  logic [31:0] lo;

  // ---------------- ALU ----------------
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_res;

  assign alu_a = bus.eshift  ? {27'b0, bus.eimm[10:6]} : bus.ea;
  assign alu_b = bus.ealuimm ? bus.eimm : bus.eb;

  always_comb begin
    alu_res = '0;
    case (bus.ealuc[2:0])
      3'b000: alu_res = alu_a + alu_b;
      3'b100: alu_res = alu_a - alu_b;
      3'b001: alu_res = alu_a & alu_b;
      3'b101: alu_res = alu_a | alu_b;
      3'b010: alu_res = alu_a ^ alu_b;
      3'b110: alu_res = {alu_b[15:0], 16'b0};
      3'b011: alu_res = alu_b << alu_a[4:0];
      3'b111: alu_res = bus.ealuc[3] ? 32'($signed(alu_b) >>> alu_a[4:0])
                                     : (alu_b >> alu_a[4:0]);
      default: alu_res = '0;
    endcase
  end

  // ---------------- op decode / stall ----------------
  logic md_start;
  logic md_any;
  logic md_sgn;
  logic is_mfhi;
  logic is_mflo;

  assign md_start = (bus.emdop >= 3'd1) && (bus.emdop <= 3'd4);
  assign md_any   = (bus.emdop >= 3'd1) && (bus.emdop <= 3'd6);
  assign md_sgn   = (bus.emdop == 3'd1) || (bus.emdop == 3'd3);
  assign is_mfhi  = (bus.emdop == 3'd5);
  assign is_mflo  = (bus.emdop == 3'd6);

  assign bus.estall = (state == BUSY) && md_any;
  assign bus.mdbusy = (state == BUSY);

  assign bus.ealu = bus.ejal ? (bus.epc4 + 32'd4) :
                    is_mfhi  ? hi :
                    is_mflo  ? lo : alu_res;
  assign bus.ern    = bus.ern0 | {5{bus.ejal}};
  assign bus.xwreg  = !bus.estall && bus.ewreg && !md_start;
  assign bus.xm2reg = !bus.estall && bus.em2reg;
  assign bus.xwmem  = !bus.estall && bus.ewmem;

  // ---------------- iterative multiply / divide ----------------
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  assign mag_a = (md_sgn && bus.ea[31]) ? (~bus.ea + 32'd1) : bus.ea;
  assign mag_b = (md_sgn && bus.eb[31]) ? (~bus.eb + 32'd1) : bus.eb;

  // Multiply keeps {partial, multiplier} in acc_hi/acc_lo; divide keeps {remainder, dividend/quotient}.
  logic [32:0] mul_sum;
  logic [32:0] div_r;
  logic [33:0] div_diff;
  logic        div_ge;
  logic [31:0] step_hi;
  logic [31:0] step_lo;

  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : 33'd0);
  assign div_r    = {acc_hi, acc_lo[31]};
  assign div_diff = {1'b0, div_r} - {2'b0, opb};
  assign div_ge   = ~div_diff[33];
  assign step_hi  = md_mul ? mul_sum[32:1] : (div_ge ? div_diff[31:0] : div_r[31:0]);
  assign step_lo  = md_mul ? {mul_sum[0], acc_lo[31:1]} : {acc_lo[30:0], div_ge};

  logic [63:0] prod;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  assign prod     = {step_hi, step_lo};
  assign prod_fix = neg_q ? (~prod + 64'd1) : prod;
  // A zero divisor leaves the dividend magnitude in the remainder, so only the quotient needs overriding.
  assign quo_fix  = (opb == 32'd0) ? 32'hFFFF_FFFF : (neg_q ? (~step_lo + 32'd1) : step_lo);
  assign rem_fix  = neg_r ? (~step_hi + 32'd1) : step_hi;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      cnt    <= '0;
      md_mul <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      opb    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (md_start) begin
            state  <= BUSY;
            cnt    <= '0;
            md_mul <= (bus.emdop == 3'd1) || (bus.emdop == 3'd2);
            neg_q  <= md_sgn && (bus.ea[31] ^ bus.eb[31]);
            neg_r  <= md_sgn && bus.ea[31];
            opb    <= mag_b;
            acc_hi <= '0;
            acc_lo <= mag_a;
          end
        end
        BUSY: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + 6'd1;
          if (cnt == LAST_STEP) begin
            state <= IDLE;
            cnt   <= '0;
            if (md_mul) begin
              hi <= prod_fix[63:32];
              lo <= prod_fix[31:0];
            end else begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
